// File: rtl/spi_mnrch_param.sv
// Parametrised SPI monarch: shifts a WIDTH-bit command out on MOSI (MSB first)
// while capturing a WIDTH-bit response from MISO. SCLK idles high, MISO is
// sampled on the SCLK rise, and the shift register advances at the end of each
// bit period. With hold set, SS_n stays low so the next frame can be chained.
module spi_mnrch_param #(
    parameter int WIDTH    = 16,
    parameter int SCLK_DIV = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             snd,
    input  logic [WIDTH-1:0] cmd,
    input  logic             hold,
    input  logic             rls,
    input  logic             MISO,
    output logic             SS_n,
    output logic             SCLK,
    output logic             MOSI,
    output logic             done,
    output logic             busy,
    output logic [WIDTH-1:0] resp
);

    localparam int HALF  = SCLK_DIV / 2;
    localparam int CNT_W = $clog2(SCLK_DIV);
    localparam int BIT_W = $clog2(WIDTH + 1);

    // Divider count at the last clock of the low phase / of the whole period.
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] PER_END  = CNT_W'(SCLK_DIV - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRONT = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   shreg, shreg_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [BIT_W-1:0]   bit_cnt, bit_cnt_nxt;
    logic               miso_q, miso_nxt;
    logic               hold_q, hold_nxt;
    logic               ss_n_nxt, sclk_nxt, done_nxt;

    assign MOSI = shreg[WIDTH-1];
    assign resp = shreg;
    assign busy = (state == FRONT) || (state == SHIFT);

    // Next-state and next-value logic for every register in the block.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the
        // case below can leave one unassigned and infer a latch.
        state_nxt   = state;
        shreg_nxt   = shreg;
        cnt_nxt     = cnt;
        bit_cnt_nxt = bit_cnt;
        miso_nxt    = miso_q;
        hold_nxt    = hold_q;
        ss_n_nxt    = SS_n;
        sclk_nxt    = SCLK;
        done_nxt    = done;

        case (state)
            IDLE, HOLD: begin
                if (snd) begin
                    // Start a frame; from HOLD SS_n is already low and stays low.
                    shreg_nxt   = cmd;
                    hold_nxt    = hold;
                    done_nxt    = 1'b0;
                    cnt_nxt     = '0;
                    bit_cnt_nxt = '0;
                    ss_n_nxt    = 1'b0;
                    sclk_nxt    = 1'b1;
                    state_nxt   = FRONT;
                end else if ((state == HOLD) && rls) begin
                    ss_n_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end

            FRONT: begin
                if (cnt == HALF_END) begin
                    cnt_nxt   = '0;
                    sclk_nxt  = 1'b0;
                    state_nxt = SHIFT;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            SHIFT: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == HALF_END) begin
                    // Rising edge of SCLK: capture MISO, MOSI is left alone.
                    sclk_nxt    = 1'b1;
                    miso_nxt    = MISO;
                    bit_cnt_nxt = bit_cnt + 1'b1;
                end else if (cnt == PER_END) begin
                    shreg_nxt = {shreg[WIDTH-2:0], miso_q};
                    cnt_nxt   = '0;
                    if (bit_cnt == LAST_BIT) begin
                        done_nxt  = 1'b1;
                        ss_n_nxt  = ~hold_q;
                        state_nxt = hold_q ? HOLD : IDLE;
                    end else begin
                        sclk_nxt = 1'b0;
                    end
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers
        // update together from values sampled before the edge.
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            cnt     <= '0;
            bit_cnt <= '0;
            miso_q  <= 1'b0;
            hold_q  <= 1'b0;
            SS_n    <= 1'b1;
            SCLK    <= 1'b1;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            cnt     <= cnt_nxt;
            bit_cnt <= bit_cnt_nxt;
            miso_q  <= miso_nxt;
            hold_q  <= hold_nxt;
            SS_n    <= ss_n_nxt;
            SCLK    <= sclk_nxt;
            done    <= done_nxt;
        end
    end

endmodule

// File: tb/tb_spi_mnrch_param.sv
// Bench for spi_mnrch_param: a default-size instance talking to a small
// inertial-sensor serf model (or looped back), plus an 8-bit fast instance in
// loopback. Expected responses go into queues when frames are issued; a monitor
// pops and compares them on every rising edge of done.
module tb_spi_mnrch_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // Default instance (WIDTH=16, SCLK_DIV=32)
    logic        snd_a = 1'b0, hold_a = 1'b0, rls_a = 1'b0;
    logic [15:0] cmd_a = '0;
    logic        miso_a, ss_a, sclk_a, mosi_a, done_a, busy_a;
    logic [15:0] resp_a;
    logic        loop_a = 1'b0;

    // Small instance (WIDTH=8, SCLK_DIV=4), MISO looped to MOSI
    logic        snd_b = 1'b0, hold_b = 1'b0, rls_b = 1'b0;
    logic [7:0]  cmd_b = '0;
    logic        ss_b, sclk_b, mosi_b, done_b, busy_b;
    logic [7:0]  resp_b;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] exp_a[$];
    logic [7:0]  exp_b[$];

    always #5 clk = ~clk;

    // Serf model: echoes WHO_AM_I=0x6A for a 0x8F read, raises INT after a
    // 0x0D/0x02 write. Drives MISO on SCLK falls, samples MOSI on SCLK rises.
    logic        serf_miso = 1'b0;
    logic [15:0] serf_rx = '0;
    logic [15:0] serf_rd = '0;
    int          serf_idx = 0;
    logic        int_pin = 1'b0;
    logic        ss_prev = 1'b1, sclk_prev = 1'b1;

    always @(ss_a or sclk_a) begin
        if (ss_prev === 1'b1 && ss_a === 1'b0) begin
            serf_idx = 0;
            serf_rd  = '0;
            serf_rx  = '0;
        end else if (ss_a === 1'b0 && sclk_prev === 1'b1 && sclk_a === 1'b0) begin
            if (serf_idx == 8 && serf_rx[7:0] == 8'h8F) serf_rd = 16'h006A;
            if (serf_idx < 16) serf_miso = serf_rd[15-serf_idx];
            serf_idx++;
        end else if (ss_a === 1'b0 && sclk_prev === 1'b0 && sclk_a === 1'b1) begin
            serf_rx = {serf_rx[14:0], mosi_a};
        end
        if (ss_prev === 1'b0 && ss_a === 1'b1 && serf_rx == 16'h0D02) int_pin = 1'b1;
        ss_prev   = ss_a;
        sclk_prev = sclk_a;
    end

    assign miso_a = loop_a ? mosi_a : serf_miso;

    spi_mnrch_param #(.WIDTH(16), .SCLK_DIV(32)) dut_a (
        .clk(clk), .rst(rst), .snd(snd_a), .cmd(cmd_a), .hold(hold_a), .rls(rls_a),
        .MISO(miso_a), .SS_n(ss_a), .SCLK(sclk_a), .MOSI(mosi_a),
        .done(done_a), .busy(busy_a), .resp(resp_a)
    );

    spi_mnrch_param #(.WIDTH(8), .SCLK_DIV(4)) dut_b (
        .clk(clk), .rst(rst), .snd(snd_b), .cmd(cmd_b), .hold(hold_b), .rls(rls_b),
        .MISO(mosi_b), .SS_n(ss_b), .SCLK(sclk_b), .MOSI(mosi_b),
        .done(done_b), .busy(busy_b), .resp(resp_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compare resp against the queue head on each done rise.
    task automatic monitor();
        logic pa, pb;
        pa = done_a;
        pb = done_b;
        forever begin
            @(negedge clk);
            if (done_a === 1'b1 && pa !== 1'b1) begin
                if (exp_a.size() == 0) check("done_a_unexpected", exp_a.size(), 1);
                else check("resp_a", resp_a, exp_a.pop_front());
            end
            if (done_b === 1'b1 && pb !== 1'b1) begin
                if (exp_b.size() == 0) check("done_b_unexpected", exp_b.size(), 1);
                else check("resp_b", resp_b, exp_b.pop_front());
            end
            pa = done_a;
            pb = done_b;
        end
    endtask

    task automatic send_a(input logic [15:0] c, input logic h);
        @(posedge clk); #1;
        snd_a = 1'b1; cmd_a = c; hold_a = h;
        @(posedge clk); #1;
        snd_a = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] c);
        @(posedge clk); #1;
        snd_b = 1'b1; cmd_b = c; hold_b = 1'b0;
        @(posedge clk); #1;
        snd_b = 1'b0;
    endtask

    // Count SS_n-low cycles, SCLK rises and MOSI changes coincident with a rise
    // until SS_n returns high (bounded).
    task automatic measure(input bit sel, output int low, output int rises, output int bad);
        logic sp, mp, s, k, m;
        low = 0; rises = 0; bad = 0;
        sp = sel ? sclk_b : sclk_a;
        mp = sel ? mosi_b : mosi_a;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            s = sel ? ss_b : ss_a;
            k = sel ? sclk_b : sclk_a;
            m = sel ? mosi_b : mosi_a;
            if (s === 1'b1) break;
            low++;
            if (sp === 1'b0 && k === 1'b1) begin
                rises++;
                if (m !== mp) bad++;
            end
            sp = k;
            mp = m;
        end
    endtask

    // Wait (bounded) for done on instance A, counting cycles with SS_n high.
    task automatic wait_done_a(input string name, output int ss_hi);
        bit seen;
        seen = 0;
        ss_hi = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (ss_a !== 1'b0) ss_hi++;
            if (done_a === 1'b1) seen = 1;
        end
        check(name, seen, 1);
    endtask

    initial begin
        int low, rises, bad, hi;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ss_a", ss_a, 1);
        check("rst_sclk_a", sclk_a, 1);
        check("rst_done_a", done_a, 0);
        check("rst_busy_a", busy_a, 0);
        check("rst_resp_a", resp_a, 0);
        check("rst_mosi_a", mosi_a, 0);
        check("rst_ss_b", ss_b, 1);
        check("rst_resp_b", resp_b, 0);
        rst = 1'b0;

        fork
            monitor();
        join_none

        // WHO_AM_I read from the serf model
        exp_a.push_back(16'h006A);
        send_a(16'h8F00, 1'b0);
        measure(1'b0, low, rises, bad);
        check("who_ss_low_cycles", low, 528);
        check("who_sclk_rises", rises, 16);
        check("who_mosi_at_rise", bad, 0);
        check("who_int_idle", int_pin, 0);
        #1;
        check("who_busy_after", busy_a, 0);
        check("who_done_after", done_a, 1);

        // INT configuration write, INT seen after the frame
        exp_a.push_back(16'h0000);
        send_a(16'h0D02, 1'b0);
        measure(1'b0, low, rises, bad);
        check("int_ss_low_cycles", low, 528);
        repeat (2) @(posedge clk);
        #1;
        check("int_ss_high", ss_a, 1);
        check("int_pin_high", int_pin, 1);

        // Small instance loopback
        exp_b.push_back(8'hA5);
        send_b(8'hA5);
        measure(1'b1, low, rises, bad);
        check("b_ss_low_cycles", low, 34);
        check("b_sclk_rises", rises, 8);
        check("b_mosi_at_rise", bad, 0);

        // Chained frames in loopback
        loop_a = 1'b1;
        exp_a.push_back(16'h1234);
        exp_a.push_back(16'hBEEF);
        send_a(16'h1234, 1'b1);
        wait_done_a("chain1_done", hi);
        check("chain1_ss_high_cycles", hi, 0);
        repeat (3) @(posedge clk);
        #1;
        check("hold_ss_low", ss_a, 0);
        check("hold_busy", busy_a, 0);
        check("hold_sclk", sclk_a, 1);
        send_a(16'hBEEF, 1'b0);
        check("chain2_done_drop", done_a, 0);
        check("chain2_ss_low", ss_a, 0);
        measure(1'b0, low, rises, bad);
        check("chain2_ss_low_cycles", low, 528);
        #1;
        check("chain2_ss_high_end", ss_a, 1);

        // HOLD then release
        exp_a.push_back(16'h00FF);
        send_a(16'h00FF, 1'b1);
        wait_done_a("rls_frame_done", hi);
        @(posedge clk); #1;
        check("rls_pre_ss", ss_a, 0);
        rls_a = 1'b1;
        @(posedge clk); #1;
        rls_a = 1'b0;
        check("rls_ss_high", ss_a, 1);
        check("rls_done_kept", done_a, 1);
        check("rls_busy", busy_a, 0);

        // snd and rls together in HOLD: snd wins
        exp_a.push_back(16'h5A5A);
        exp_a.push_back(16'h3C3C);
        send_a(16'h5A5A, 1'b1);
        wait_done_a("sndrls_frame1_done", hi);
        @(posedge clk); #1;
        snd_a = 1'b1; rls_a = 1'b1; cmd_a = 16'h3C3C; hold_a = 1'b0;
        @(posedge clk); #1;
        snd_a = 1'b0; rls_a = 1'b0;
        check("sndrls_ss_low", ss_a, 0);
        check("sndrls_busy", busy_a, 1);
        check("sndrls_done_drop", done_a, 0);
        measure(1'b0, low, rises, bad);
        check("sndrls_ss_low_cycles", low, 528);

        // snd while busy is ignored
        exp_a.push_back(16'h1111);
        send_a(16'h1111, 1'b0);
        repeat (100) @(posedge clk);
        #1;
        snd_a = 1'b1; cmd_a = 16'hFFFF; hold_a = 1'b1;
        @(posedge clk); #1;
        snd_a = 1'b0; hold_a = 1'b0;
        measure(1'b0, low, rises, bad);
        repeat (5) @(posedge clk);
        #1;
        check("busy_snd_resp_stable", resp_a, 16'h1111);
        check("busy_snd_ss_idle", ss_a, 1);

        // Reset mid-SHIFT aborts without a done
        send_a(16'h2222, 1'b0);
        repeat (200) @(posedge clk);
        #1;
        check("abort_in_shift", busy_a, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_ss", ss_a, 1);
        check("abort_sclk", sclk_a, 1);
        check("abort_done", done_a, 0);
        check("abort_resp", resp_a, 0);
        check("abort_busy", busy_a, 0);
        repeat (600) @(posedge clk);
        #1;
        check("abort_stays_idle", ss_a, 1);

        check("queue_a_empty", exp_a.size(), 0);
        check("queue_b_empty", exp_b.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
